// File: rtl/tester_pkg.sv
// Shared types for the evolved-circuit tester: sequencer states and the score width helper.
package tester_pkg;

   typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, EVAL, DONE} state_e;

   // Score counts 0..nv inclusive, so it needs one more code than nv vectors.
   function automatic int score_w(input int nv);
      return $clog2(nv + 1);
   endfunction

endpackage

// File: rtl/evolved_circuit_tester_sync2.sv
// Two-flop synchronizer bringing the asynchronous circuit-under-test output into clk.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/evolved_circuit_tester.sv
// Test sequencer for evolved LCELL circuits: walks every input vector, lets the output settle,
// samples it repeatedly and scores correctness and stability against a target truth table.
module evolved_circuit_tester
   import tester_pkg::*;
#(
   parameter int                          NUM_INPUTS    = 2,
   parameter logic [(1<<NUM_INPUTS)-1:0]  EXPECTED      = 4'b0110,
   parameter int                          SETTLE_CYCLES = 16,
   parameter int                          SAMPLES       = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   output logic [NUM_INPUTS-1:0]                dut_in,
   input  logic                                 dut_out,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 pass,
   output logic [(1<<NUM_INPUTS)-1:0]           fail_vec,
   output logic [(1<<NUM_INPUTS)-1:0]           unstable_vec,
   output logic [score_w(1<<NUM_INPUTS)-1:0]    score
);

   localparam int NV  = 1 << NUM_INPUTS;
   localparam int SCW = score_w(NV);
   localparam int STW = $clog2(SETTLE_CYCLES);
   localparam int SMW = $clog2(SAMPLES);
   localparam logic [STW-1:0]        SETTLE_LOAD = STW'(SETTLE_CYCLES - 1);
   localparam logic [SMW-1:0]        SAMP_LOAD   = SMW'(SAMPLES - 1);
   localparam logic [NUM_INPUTS-1:0] VEC_LAST    = NUM_INPUTS'(NV - 1);
   localparam logic [SCW-1:0]        SCORE_FULL  = SCW'(NV);

   state_e                  state_q, state_d;
   logic [NUM_INPUTS-1:0]   vec_q, vec_d;
   logic [NUM_INPUTS-1:0]   dut_in_q, dut_in_d;
   logic [STW-1:0]          settle_q, settle_d;
   logic [SMW-1:0]          samp_q, samp_d;
   logic                    ref_q, ref_d;
   logic                    unstab_q, unstab_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    pass_q, pass_d;
   logic [NV-1:0]           fail_q, fail_d;
   logic [NV-1:0]           uvec_q, uvec_d;
   logic [SCW-1:0]          score_q, score_d;
   logic                    sync_out;
   logic                    good;

   sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (dut_out),
      .q     (sync_out)
   );

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      dut_in_d = dut_in_q;
      settle_d = settle_q;
      samp_d   = samp_q;
      ref_d    = ref_q;
      unstab_d = unstab_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      fail_d   = fail_q;
      uvec_d   = uvec_q;
      score_d  = score_q;
      good     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               fail_d  = '0;
               uvec_d  = '0;
               score_d = '0;
               pass_d  = 1'b0;
               vec_d   = '0;
               state_d = APPLY;
            end
         end
         APPLY: begin
            dut_in_d = vec_q;
            settle_d = SETTLE_LOAD;
            unstab_d = 1'b0;
            state_d  = SETTLE;
         end
         SETTLE: begin
            if (settle_q == '0) begin
               samp_d  = SAMP_LOAD;
               state_d = SAMPLE;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         SAMPLE: begin
            // The first sample of the window is the reference every later one must match.
            if (samp_q == SAMP_LOAD) begin
               ref_d = sync_out;
            end else if (sync_out != ref_q) begin
               unstab_d = 1'b1;
            end
            if (samp_q == '0) begin
               state_d = EVAL;
            end else begin
               samp_d = samp_q - 1'b1;
            end
         end
         EVAL: begin
            good           = (ref_q == EXPECTED[vec_q]) && !unstab_q;
            fail_d[vec_q]  = !good;
            uvec_d[vec_q]  = unstab_q;
            if (good) begin
               score_d = score_q + 1'b1;
            end
            if (vec_q == VEC_LAST) begin
               state_d = DONE;
            end else begin
               vec_d   = vec_q + 1'b1;
               state_d = APPLY;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            pass_d  = (score_q == SCORE_FULL);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         vec_q    <= '0;
         dut_in_q <= '0;
         settle_q <= '0;
         samp_q   <= '0;
         ref_q    <= 1'b0;
         unstab_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         fail_q   <= '0;
         uvec_q   <= '0;
         score_q  <= '0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         dut_in_q <= dut_in_d;
         settle_q <= settle_d;
         samp_q   <= samp_d;
         ref_q    <= ref_d;
         unstab_q <= unstab_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         uvec_q   <= uvec_d;
         score_q  <= score_d;
      end
   end

   assign dut_in       = dut_in_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign fail_vec     = fail_q;
   assign unstable_vec = uvec_q;
   assign score        = score_q;

endmodule

// File: doc/evolved_circuit_tester.md
# evolved_circuit_tester

Hardware test sequencer for small evolved LCELL circuits: the 2-input, 1-output combinational-loop netlists the team evolves and drops into the fabric. On `start` it walks every input vector of the circuit under test, waits a settle window, samples the asynchronous output repeatedly, and records per vector both correctness against a target truth table and stability (no oscillation). It sits between the evolution host interface and one circuit-under-test instance. It produces a fitness score and pass/fail flags.

## Interface
- `NUM_INPUTS`, default 2: width of the circuit-under-test input bus; vector count `NV = 2**NUM_INPUTS`.
- `EXPECTED`, default `4'b0110`: target truth table, `NV` bits; bit `v` is the required output for input vector `v`.
- `SETTLE_CYCLES`, default 16: cycles waited after applying a vector before sampling; must be ≥3.
- `SAMPLES`, default 8: consecutive output samples taken per vector; must be ≥2.

- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a test run; sampled only in IDLE.
- `dut_in`, out, `NUM_INPUTS`: drives the circuit-under-test `in` bus; registered.
- `dut_out`, in, 1: circuit-under-test `out`; asynchronous, passed through a 2-flop synchronizer.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at end of run.
- `pass`, out, 1: all vectors correct and stable; held until next accepted `start`.
- `fail_vec`, out, `NV`: bit `v` set if vector `v` was wrong or unstable.
- `unstable_vec`, out, `NV`: bit `v` set if samples for vector `v` disagreed.
- `score`, out, `$clog2(NV+1)`: count of correct and stable vectors.

## Operation
- Reset values: all outputs 0, `dut_in` = 0, state IDLE, vector index 0.
- FSM states and transitions:
  - IDLE: if `start`, clear `fail_vec`, `unstable_vec`, `score` and `pass`, set vector index to 0, go to APPLY.
  - APPLY: 1 cycle; `dut_in` ← vector index; go to SETTLE.
  - SETTLE: exactly `SETTLE_CYCLES` cycles (down-counter), then go to SAMPLE.
  - SAMPLE: exactly `SAMPLES` cycles; the first synchronized sample is stored as `ref`; any later sample ≠ `ref` sets the unstable flag for the current vector.
  - EVAL: 1 cycle; vector is good iff `ref == EXPECTED[v]` and it is stable. If not good, set `fail_vec[v]`; if good, increment `score`. Copy the unstable flag into `unstable_vec[v]`. If `v == NV-1`, go to DONE; otherwise increment `v` and go to APPLY.
  - DONE: 1 cycle; `done`=1, `pass` ← (`score == NV`); go to IDLE.
- `start` while busy is ignored; it is not queued.
- After a run, `dut_in` holds the last vector until the next run or reset.
- Width rules:
  - Vector index is `NUM_INPUTS` bits; the last-vector compare prevents wrap-around.
  - Sample and settle counters are sized with `$clog2` of their parameter; the counters never overflow.
- Reset mid-run: immediate return to reset values. No `done` pulse is produced, and no partial results are retained.

## Timing
- Per vector: `SETTLE_CYCLES + SAMPLES + 2` cycles (APPLY + SETTLE + SAMPLE + EVAL).
- `start` accepted at edge k → `done` high during cycle k + `NV*(SETTLE_CYCLES+SAMPLES+2)` + 1. With defaults, that is k+105.
- The synchronizer adds 2 cycles. With `SETTLE_CYCLES` ≥3, the first sample reflects an output that has had at least `SETTLE_CYCLES-2` cycles to settle.
- `pass`, `score`, `fail_vec` and `unstable_vec` are valid from the `done` cycle and remain stable until the next accepted `start`.

## Structure
- Package `tester_pkg`:
  - state enum `{IDLE, APPLY, SETTLE, SAMPLE, EVAL, DONE}`;
  - width helper function for `score`.
- Sub-module `sync2`: a 2-flop synchronizer with async active-low reset, used on `dut_out`.

## Test plan
- XOR behavioural circuit model (3-cycle delay), defaults → `done` at k+105, `pass`=1, `score`=4, `fail_vec`=0000, `unstable_vec`=0000.
- Circuit output stuck at 0 → `pass`=0, `score`=2, `fail_vec`=0110, `unstable_vec`=0000.
- XOR model, but output toggles every cycle on vector 3 → `unstable_vec`=1000, `fail_vec`=1000, `score`=3.
- XOR model with a 20-cycle output delay (> `SETTLE_CYCLES`) → each vector samples the previous output transitioning. The bench requires nonzero `fail_vec`, `pass`=0, and flags consistent with the model.
- `start` pulsed at cycle 40 of a run → no restart, `done` still at k+105, single `done` pulse.
- `rst_n` low at cycle 50 → all outputs 0 within the reset assertion, `dut_in`=0, no `done` pulse. A fresh `start` after release completes normally with `pass`=1.
